// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seqdet_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  // Helpers work on a fixed 32-bit width; callers size-cast to MAX_LEN.
  localparam int MASK_W = 32;

  function automatic bit len_ok(input int len, input int max_len);
    return (len >= 2) && (len <= max_len);
  endfunction

  function automatic logic [MASK_W-1:0] len_mask(input int len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) m[i] = (i < len);
    return m;
  endfunction

endpackage

// File: rtl/seqdet_window.sv
// Bit history shift register and saturating fill counter; hist_next/fill_next
// show the values an accepted beat would load.
module seqdet_window #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift,
  input  logic               fill_zero,
  input  logic               in_bit,
  output logic [MAX_LEN-1:0] hist_next,
  output logic [LEN_W-1:0]   fill_next
);

  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;

  assign hist_next = {hist[MAX_LEN-2:0], in_bit};
  assign fill_next = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_next;
      fill <= fill_zero ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector: registered match pulse one cycle
// after the completing beat, saturating match counter. SEQDET_MASK_EN adds cfg_mask.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
`ifdef SEQDET_MASK_EN
  input  logic [MAX_LEN-1:0] cfg_mask,
`endif
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed,
  output logic               cfg_err
);

  import seqdet_pkg::*;

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] lmask;
  logic [MAX_LEN-1:0] cmp_mask;
  logic               cfg_legal;
  logic               beat;
  logic               hit;

  assign cfg_legal = len_ok(int'(cfg_len), MAX_LEN);
  assign lmask     = MAX_LEN'(len_mask(int'(len_q)));

`ifdef SEQDET_MASK_EN
  logic [MAX_LEN-1:0] mask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      mask_q <= '0;
    else if (cfg_load && cfg_legal) mask_q <= cfg_mask;
  end

  assign cmp_mask = lmask & mask_q;
`else
  assign cmp_mask = lmask;
`endif

  // A cfg_load swallows any beat presented in the same cycle.
  assign beat = (state == ARMED) && in_valid && !cfg_load;
  assign hit  = beat && (fill_next >= len_q) &&
                (((hist_next ^ pat_q) & cmp_mask) == '0);

  seqdet_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk       (clk),
    .reset     (reset),
    .clear     (cfg_load),
    .shift     (beat),
    .fill_zero (hit && !ovl_q),
    .in_bit    (in_bit),
    .hist_next (hist_next),
    .fill_next (fill_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      match       <= 1'b0;
      match_count <= '0;
      cfg_err     <= 1'b0;
    end else begin
      match <= hit;
      if (cfg_load) begin
        match_count <= '0;
        if (cfg_legal) begin
          state   <= ARMED;
          pat_q   <= cfg_pattern;
          len_q   <= cfg_len;
          ovl_q   <= cfg_overlap;
          cfg_err <= 1'b0;
        end else begin
          state   <= IDLE;
          cfg_err <= 1'b1;
        end
      end else if (hit && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

  assign armed = (state == ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed streams queue the expected
// match cycle and count; a negedge monitor checks every match pulse against them.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [MAX_LEN-1:0] cfg_mask;
  logic               in_valid;
  logic               in_bit;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               armed;
  logic               cfg_err;

  typedef struct {
    int               cyc;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  int               cyc    = 0;
  int               checks = 0;
  int               errs   = 0;
  logic [CNT_W-1:0] exp_cnt;

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
`ifdef SEQDET_MASK_EN
    .cfg_mask    (cfg_mask),
`endif
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .match       (match),
    .match_count (match_count),
    .armed       (armed),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a pulse must line up with the head of the scoreboard, and a head
  // entry whose cycle has passed is a missed pulse.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errs++;
      $display("FAIL missed_match: match=0 at cycle %0d, required 1", sb[0].cyc);
      void'(sb.pop_front());
    end
    if (match === 1'b1) begin
      checks++;
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        errs++;
        $display("FAIL unexpected_match: match=1 at cycle %0d, required 0", cyc);
      end else begin
        e = sb.pop_front();
        if (match_count !== e.cnt) begin
          errs++;
          $display("FAIL match_count_at_pulse: cycle %0d got %0d, required %0d",
                   cyc, match_count, e.cnt);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic b, input logic exp);
    in_valid = v;
    in_bit   = b;
    if (exp) begin
      if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
      sb.push_back('{cyc: cyc + 1, cnt: exp_cnt});
    end
    tick();
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  // Bit n-1 of b goes first; e marks the beats expected to complete a match.
  task automatic stream(input logic [15:0] b, input logic [15:0] e,
                        input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      send(1'b1, b[i], e[i]);
      for (int g = 0; g < gap; g++) send(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic do_cfg(input logic [MAX_LEN-1:0] pat, input int len, input logic ov,
                        input logic bv, input logic bb);
    logic [31:0] l;
    l           = len;
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = l[LEN_W-1:0];
    cfg_overlap = ov;
    in_valid    = bv;
    in_bit      = bb;
    tick();
    // Scramble config afterwards: only the load cycle may be sampled.
    cfg_load    = 1'b0;
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    cfg_pattern = ~pat;
    cfg_len     = LEN_W'(2);
    cfg_overlap = ~ov;
    exp_cnt     = '0;
  endtask

  initial begin
    reset       = 1'b1;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    cfg_mask    = '1;
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    exp_cnt     = '0;
    repeat (2) tick();
    check("reset_match", match, 0);
    check("reset_count", match_count, 0);
    check("reset_armed", armed, 0);
    check("reset_cfg_err", cfg_err, 0);
    reset = 1'b0;
    tick();

    // Unconfigured IDLE ignores beats.
    stream(16'b1101, 16'b0, 4, 0);

    // Non-overlapping 1101 over 1101101: one hit on bit 4.
    do_cfg(8'b0000_1101, 4, 1'b0, 1'b0, 1'b0);
    check("armed_after_load", armed, 1);
    check("cfg_err_after_load", cfg_err, 0);
    stream(16'b1101101, 16'b0001000, 7, 0);
    tick();
    check("nonoverlap_count", match_count, 1);

    // Overlapping: hits on bits 4 and 7.
    do_cfg(8'b0000_1101, 4, 1'b1, 1'b0, 1'b0);
    check("count_cleared_by_load", match_count, 0);
    stream(16'b1101101, 16'b0001001, 7, 0);
    tick();
    check("overlap_count", match_count, 2);

    // Three idle cycles between every valid beat.
    do_cfg(8'b0000_1101, 4, 1'b0, 1'b0, 1'b0);
    stream(16'b1101, 16'b0001, 4, 3);
    tick();
    check("gap_count", match_count, 1);

    // Asynchronous reset part-way through a pattern.
    stream(16'b110, 16'b0, 3, 0);
    #2 reset = 1'b1;
    #1;
    check("midreset_match", match, 0);
    check("midreset_count", match_count, 0);
    check("midreset_armed", armed, 0);
    tick();
    reset   = 1'b0;
    exp_cnt = '0;
    tick();
    do_cfg(8'b0000_1101, 4, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    stream(16'b1101, 16'b0001, 4, 0);
    tick();
    check("rearm_count", match_count, 1);

    // A beat coinciding with cfg_load is discarded along with the history.
    do_cfg(8'b0000_1101, 4, 1'b1, 1'b0, 1'b0);
    stream(16'b110, 16'b0, 3, 0);
    do_cfg(8'b0000_1101, 4, 1'b1, 1'b1, 1'b1);
    stream(16'b1101, 16'b0001, 4, 0);
    tick();
    check("load_wins_count", match_count, 1);

    // Illegal lengths fall back to IDLE with a sticky error.
    do_cfg(8'b0000_1101, 0, 1'b0, 1'b0, 1'b0);
    check("len0_cfg_err", cfg_err, 1);
    check("len0_armed", armed, 0);
    check("len0_count", match_count, 0);
    stream(16'b1101, 16'b0, 4, 0);
    do_cfg(8'b0000_1101, MAX_LEN + 1, 1'b0, 1'b0, 1'b0);
    check("len9_cfg_err", cfg_err, 1);
    check("len9_armed", armed, 0);
    stream(16'b1101, 16'b0, 4, 0);
    do_cfg(8'b0000_1101, 4, 1'b0, 1'b0, 1'b0);
    check("legal_clears_cfg_err", cfg_err, 0);
    check("legal_rearms", armed, 1);

    // Overlapping "11" over six ones: five pulses, counter sticks at 3.
    do_cfg(8'b0000_0011, 2, 1'b1, 1'b0, 1'b0);
    stream(16'b111111, 16'b011111, 6, 0);
    tick();
    check("saturated_count", match_count, 3);

    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Programmable serial bit-pattern detector. It is the parametrised successor of the team's fixed 4-bit Mealy "1101" detector.
- Pattern, pattern length and overlap mode are loaded at run time.
- Input is valid-qualified, so it tolerates gaps in the bit stream.
- Outputs are a registered match pulse and a saturating match counter.
- Sits between a serial front-end (deserialiser or line sampler) and control logic consuming frame-sync or keyword hits.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>= 2).
LEN_W, $clog2(MAX_LEN+1), width of the length field.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
cfg_load  input  1  single-cycle strobe; latches cfg_pattern, cfg_len, cfg_overlap.
cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last.
cfg_len  input  LEN_W  pattern length; legal range 2..MAX_LEN.
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
in_valid  input  1  qualifies in_bit.
in_bit  input  1  serial data bit.
match  output  1  one-cycle pulse, the cycle after the completing bit.
match_count  output  CNT_W  saturating count of matches since the last reset or cfg_load.
armed  output  1  high while in ARMED.
cfg_err  output  1  sticky; set when a cfg_load carries an illegal cfg_len.

Behaviour:
- Reset (async, high): state=IDLE. match=0, match_count=0, armed=0, cfg_err=0. History register and fill counter cleared; config registers cleared.
- FSM states and transitions (in seqdet_pkg):
  - IDLE: ignores in_valid. cfg_load with legal len -> ARMED. cfg_load with illegal len (0, 1, >MAX_LEN) -> cfg_err=1, remain IDLE.
  - ARMED: processes bits. cfg_load with legal len -> latch new config, clear history/fill/count/cfg_err, stay ARMED. cfg_load with illegal len -> cfg_err=1, go IDLE, clear history and count.
- Datapath, per accepted beat (in_valid=1 in ARMED):
  - hist <= {hist[MAX_LEN-2:0], in_bit}.
  - fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated on the incoming beat:
  - fill_next >= len, and
  - the low len bits of hist_next equal the low len bits of pattern.
- On match, next cycle: match=1 and match_count increments, saturating at 2^CNT_W-1 without wrapping.
- Non-overlap mode: on match, fill is forced to 0, so the next match needs len fresh bits. hist contents are don't-care.
- Overlap mode: fill is not cleared, so consecutive matches may share bits.
- in_valid=0: no state change. match=0 in the following cycle.
- cfg_load in the same cycle as a valid beat: cfg_load wins. The beat is discarded, no match is produced, and new config is effective from the next cycle.
- Latency: exactly 1 cycle from the completing beat to match; back-to-back pulses are possible in overlap mode.
- Config ports are sampled only on cfg_load; changes at other times have no effect.

Optional Feature:
Macro SEQDET_MASK_EN.
- Defined: adds port cfg_mask (input, MAX_LEN), latched on cfg_load. A mask bit of 0 makes the corresponding pattern bit don't-care. The compare becomes ((hist ^ pattern) & mask & lenmask) == 0. A fully-zero mask within len matches every beat once fill >= len.
- Undefined: port absent; all bits are compared.

Decomposition:
- Package seqdet_pkg:
  - state_t enum {IDLE, ARMED}.
  - function len_ok(len, MAX_LEN).
  - function len_mask(len) returning a MAX_LEN-bit mask of len ones.
- Sub-module seqdet_window: history shift register plus saturating fill counter, with clear input. Outputs hist_next and fill_next.
- FSM, compare logic and counter live in the top module.

Test Plan:
- Non-overlap "1101", len=4: stream 1101101 -> match pulses 1 cycle after bit 4 only; match_count=1.
- Overlap mode, same pattern and stream -> matches after bits 4 and 7; match_count=2.
- Gaps: "1101" delivered with in_valid low for 3 cycles between each bit -> single match 1 cycle after the 4th valid beat.
- Reset mid-operation: reset asserted after "110" -> outputs 0 immediately. After re-arming, "1" alone does not match; a full "1101" does.
- cfg_load with len=0, then with len=MAX_LEN+1 -> cfg_err=1, armed=0, no matches. A later legal cfg_load -> cfg_err=0, armed=1.
- Saturation: CNT_W=2, overlap, pattern "11", stream of 6 ones -> match_count reaches 3 and holds; match pulses 5 times.
